// File: rtl/div_unit_pkg.sv
// Shared constants, FSM encodings and result payload for the iterative divider.
package div_unit_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ANS_W          = 64;
  localparam int unsigned CNT_W          = 6;
  localparam int unsigned DIV_ITERATIONS = 32;

  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_BUSY    = 2'd2,
    ST_DONE    = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
  } div_result_t;

  // Absolute value for signed operands, raw value otherwise.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
    return neg ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial subtract of the divisor from {rem, next dividend bit}.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next_c,
  output logic              q_bit_c
);

  logic [DATA_W:0]   trial;
  logic [DATA_W+1:0] diff;
  logic              unused_bits;

  assign trial = {rem, dividend_bit};
  // Extra top bit carries the borrow; trial < 2*divisor so the low 32 bits hold the new remainder.
  assign diff  = {1'b0, trial} - {2'b00, divisor};

  assign q_bit_c    = ~diff[DATA_W+1];
  assign rem_next_c = q_bit_c ? diff[DATA_W-1:0] : trial[DATA_W-1:0];

  assign unused_bits = diff[DATA_W] ^ trial[DATA_W];

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned iterative divider: one quotient bit per cycle, registered result handshake.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_start,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic              in_annul,
  output logic [ANS_W-1:0]  out_ans,
  output logic              out_ready
);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;
  logic [CNT_W-1:0]  count_q;
  logic              signed_q;
  logic              sign1_q;
  logic              sign2_q;

  logic [DATA_W-1:0] rem_next;
  logic              q_bit;
  logic              count_done;
  div_result_t       fixed;
  div_result_t       ans_d;
  logic              ready_d;

  div_step u_step (
    .rem          (rem_q),
    .dividend_bit (dividend_q[DATA_W-1]),
    .divisor      (divisor_q),
    .rem_next_c   (rem_next),
    .q_bit_c      (q_bit)
  );

  assign count_done = (count_q == CNT_W'(DIV_ITERATIONS));

  // After 32 shifts dividend_q holds the unsigned quotient.
  assign fixed.quot = negate_if(dividend_q, signed_q && (sign1_q ^ sign2_q));
  assign fixed.rem  = negate_if(rem_q, signed_q && sign1_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_start && !in_annul) begin
          state_d = (in_data2 == '0) ? ST_DIVZERO : ST_BUSY;
        end
      end
      ST_DIVZERO: state_d = in_annul ? ST_IDLE : ST_DONE;
      ST_BUSY: begin
        if (in_annul) begin
          state_d = ST_IDLE;
        end else if (count_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!in_start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; non-zero only while in or entering DONE
  always_comb begin
    ready_d = NOT_READY;
    ans_d   = '0;
    unique case (state_q)
      ST_DIVZERO: begin
        if (state_d == ST_DONE) begin
          ready_d = READY;
        end
      end
      ST_BUSY: begin
        if (state_d == ST_DONE) begin
          ready_d = READY;
          ans_d   = fixed;
        end
      end
      ST_DONE: begin
        if (state_d == ST_DONE) begin
          ready_d = READY;
          ans_d   = div_result_t'(out_ans);
        end
      end
      default: begin
        ready_d = NOT_READY;
        ans_d   = '0;
      end
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
    end else if (state_q == ST_IDLE && state_d == ST_BUSY) begin
      dividend_q <= magnitude(in_data1, in_signed);
      divisor_q  <= magnitude(in_data2, in_signed);
      rem_q      <= '0;
      count_q    <= '0;
      signed_q   <= in_signed;
      sign1_q    <= in_data1[DATA_W-1];
      sign2_q    <= in_data2[DATA_W-1];
    end else if (state_q == ST_BUSY && state_d == ST_BUSY) begin
      dividend_q <= {dividend_q[DATA_W-2:0], q_bit};
      rem_q      <= rem_next;
      count_q    <= count_q + CNT_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ready <= NOT_READY;
      out_ans   <= '0;
    end else begin
      out_ready <= ready_d;
      out_ans   <= ans_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor checks each ready pulse.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_start = 1'b0;
  logic        in_signed = 1'b0;
  logic [31:0] in_data1 = '0;
  logic [31:0] in_data2 = '0;
  logic        in_annul = 1'b0;
  logic [63:0] out_ans;
  logic        out_ready;

  typedef struct {
    logic [63:0] ans;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_start  (in_start),
    .in_signed (in_signed),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_annul  (in_annul),
    .out_ans   (out_ans),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every rising out_ready must match the oldest expected result and its edge number
  always @(negedge clk) begin
    if (out_ready && !prev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=%h required=no_result", out_ans);
      end else begin
        mon_e = sb.pop_front();
        chk("result", out_ans, mon_e.ans);
        chk("latency_edge", 64'(cyc), 64'(mon_e.edge_no));
      end
    end
    if (!out_ready) chk("ans_zero_when_not_ready", out_ans, 64'h0);
    prev_ready = out_ready;
  end

  // Called at a negedge; the following posedge samples the request (edge 1 of lat).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit push);
    in_signed = sgn;
    in_data1  = a;
    in_data2  = b;
    in_start  = 1'b1;
    if (push) sb.push_back('{ans: exp, edge_no: cyc + lat});
  endtask

  // Hold start until ready, scrambling operands meanwhile; bounded wait.
  task automatic wait_ready();
    int n = 0;
    while (!out_ready && n < 100) begin
      @(negedge clk);
      in_data1  = $urandom;
      in_data2  = $urandom;
      in_signed = ~in_signed;
      n++;
    end
    if (!out_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic finish_op();
    in_start = 1'b0;
    @(negedge clk);
    chk("ready_drop", 64'(out_ready), 64'h0);
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat);
    issue(sgn, a, b, exp, lat, 1'b1);
    wait_ready();
    finish_op();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(out_ready), 64'h0);
    chk("reset_ans", out_ans, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    run(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

    // Annul while DONE must be ignored
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b1);
    wait_ready();
    in_annul = 1'b1;
    @(negedge clk);
    chk("annul_in_done_ignored", 64'(out_ready), 64'h1);
    in_annul = 1'b0;
    finish_op();

    run(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run(1'b0, 32'd5, 32'd0, 64'h0, 2);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
    run(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h2}, 34);
    run(1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 34);
    run(1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 34);
    run(1'b0, 32'd3, 32'd5, {32'd3, 32'd0}, 34);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);

    // Annul mid-division, then a new request on the very next cycle
    issue(1'b0, 32'd100, 32'd7, 64'h0, 34, 1'b0);
    repeat (10) @(negedge clk);
    in_annul = 1'b1;
    @(negedge clk);
    in_annul = 1'b0;
    issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1'b1);
    wait_ready();
    finish_op();

    // Annul during divide-by-zero
    issue(1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0);
    @(negedge clk);
    in_annul = 1'b1;
    @(negedge clk);
    in_annul = 1'b0;
    in_start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset at step 20 of a division
    issue(1'b1, 32'hFFFF_FF9C, 32'd3, 64'h0, 34, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy_ready", 64'(out_ready), 64'h0);
    chk("reset_busy_ans", out_ans, 64'h0);
    in_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Reset while a result is presented clears outputs immediately
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b1);
    wait_ready();
    rst = 1'b0;
    #1;
    chk("reset_done_ready", 64'(out_ready), 64'h0);
    chk("reset_done_ans", out_ans, 64'h0);
    in_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(1'b1, 32'hFFFF_FF9C, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFDF}, 34);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
